// File: rtl/exe_stage_mdu.sv
// Execute stage: single-cycle ALU, counted multiplier, restoring divider and
// sub-word store lane generation with a once-only data SRAM request.
module exe_stage_mdu #(
  parameter int XLEN            = 32,
  parameter int MUL_LAT         = 2,
  parameter int DIV_ZERO_Q_ONES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              ds_to_es_valid,
  output logic              es_allowin,
  input  logic [4:0]        ds_op,
  input  logic [XLEN-1:0]   ds_src1,
  input  logic [XLEN-1:0]   ds_src2,
  input  logic [XLEN-1:0]   ds_st_data,
  input  logic [1:0]        ds_mem_size,
  input  logic [4:0]        ds_dest,
  input  logic              ds_gr_we,
  input  logic [XLEN-1:0]   ds_pc,
  input  logic              ms_allowin,
  output logic              es_to_ms_valid,
  output logic [XLEN-1:0]   es_result,
  output logic [4:0]        es_dest,
  output logic              es_gr_we,
  output logic [XLEN-1:0]   es_pc,
  output logic [1:0]        es_mem_size,
  output logic              es_res_from_mem,
  output logic              es_fwd_valid,
  output logic [4:0]        es_fwd_dest,
  output logic              data_sram_en,
  output logic [XLEN/8-1:0] data_sram_wen,
  output logic [XLEN-1:0]   data_sram_addr,
  output logic [XLEN-1:0]   data_sram_wdata
);

  localparam int NB  = XLEN / 8;
  localparam int AW  = $clog2(NB);
  localparam int DCW = $clog2(XLEN + 1);
  localparam int MCW = 3;

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_SUB   = 5'd1;
  localparam logic [4:0] OP_AND   = 5'd2;
  localparam logic [4:0] OP_OR    = 5'd3;
  localparam logic [4:0] OP_XOR   = 5'd4;
  localparam logic [4:0] OP_SLT   = 5'd5;
  localparam logic [4:0] OP_SLTU  = 5'd6;
  localparam logic [4:0] OP_MUL   = 5'd7;
  localparam logic [4:0] OP_MULH  = 5'd8;
  localparam logic [4:0] OP_MULHU = 5'd9;
  localparam logic [4:0] OP_DIV   = 5'd10;
  localparam logic [4:0] OP_DIVU  = 5'd11;
  localparam logic [4:0] OP_MOD   = 5'd12;
  localparam logic [4:0] OP_MODU  = 5'd13;
  localparam logic [4:0] OP_LOAD  = 5'd14;
  localparam logic [4:0] OP_STORE = 5'd15;

  localparam logic [XLEN-1:0] DZ_QUO = {XLEN{1'(DIV_ZERO_Q_ONES != 0)}};

  // state | meaning: IDLE no divide | RUN one quotient bit per cycle | DONE result held
  typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} div_state_e;

  logic              es_valid_q;
  logic [4:0]        op_q;
  logic [XLEN-1:0]   src1_q, src2_q, st_data_q, pc_q;
  logic [1:0]        size_q;
  logic [4:0]        dest_q;
  logic              gr_we_q;
  logic              issued_q;
  logic [MCW-1:0]    mul_cnt_q;
  div_state_e        div_state_q;
  logic [DCW-1:0]    div_cnt_q;
  logic [XLEN-1:0]   rem_q, quo_q, dvs_q;
  logic              q_neg_q, r_neg_q, dz_q;

  logic              is_mul, is_div, is_mem, es_ready_go, capture, advance;
  logic              ds_is_mul, ds_is_div, ds_sgn, ds_a_neg, ds_b_neg;
  logic [XLEN-1:0]   ds_abs1, ds_abs2;
  logic [XLEN-1:0]   addr, res, div_quo, div_rem;
  logic [XLEN:0]     rem_shift, rem_diff;
  logic              mul_sgn;
  logic [2*XLEN-1:0] mul_a, mul_b, mul_prod;
  logic [NB-1:0]     lane_be;
  logic [XLEN-1:0]   lane_data;
  logic [AW-1:0]     lane;

  assign is_mul = (op_q == OP_MUL) || (op_q == OP_MULH) || (op_q == OP_MULHU);
  assign is_div = (op_q >= OP_DIV) && (op_q <= OP_MODU);
  assign is_mem = (op_q == OP_LOAD) || (op_q == OP_STORE);

  always_comb begin
    es_ready_go = 1'b1;
    if (is_div)      es_ready_go = (div_state_q == DIV_DONE);
    else if (is_mul) es_ready_go = (mul_cnt_q == '0);
  end

  assign es_allowin     = !es_valid_q || (es_ready_go && ms_allowin);
  assign es_to_ms_valid = es_valid_q && es_ready_go && !flush;
  assign capture        = ds_to_es_valid && es_allowin;
  assign advance        = es_to_ms_valid && ms_allowin;

  assign ds_is_mul = (ds_op == OP_MUL) || (ds_op == OP_MULH) || (ds_op == OP_MULHU);
  assign ds_is_div = (ds_op >= OP_DIV) && (ds_op <= OP_MODU);
  assign ds_sgn    = (ds_op == OP_DIV) || (ds_op == OP_MOD);
  assign ds_a_neg  = ds_sgn && ds_src1[XLEN-1];
  assign ds_b_neg  = ds_sgn && ds_src2[XLEN-1];
  assign ds_abs1   = ds_a_neg ? -ds_src1 : ds_src1;
  assign ds_abs2   = ds_b_neg ? -ds_src2 : ds_src2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      es_valid_q <= 1'b0;
      op_q       <= '0;
      src1_q     <= '0;
      src2_q     <= '0;
      st_data_q  <= '0;
      pc_q       <= '0;
      size_q     <= '0;
      dest_q     <= '0;
      gr_we_q    <= 1'b0;
    end else begin
      if (flush)        es_valid_q <= 1'b0;
      else if (capture) es_valid_q <= 1'b1;
      else if (advance) es_valid_q <= 1'b0;
      if (capture && !flush) begin
        op_q      <= ds_op;
        src1_q    <= ds_src1;
        src2_q    <= ds_src2;
        st_data_q <= ds_st_data;
        pc_q      <= ds_pc;
        size_q    <= ds_mem_size;
        dest_q    <= ds_dest;
        gr_we_q   <= ds_gr_we && (ds_op != OP_STORE);
      end
    end
  end

  // Restoring step: shift in the next dividend bit, subtract if it fits.
  assign rem_shift = {rem_q, quo_q[XLEN-1]};
  assign rem_diff  = rem_shift - {1'b0, dvs_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_state_q <= DIV_IDLE;
      div_cnt_q   <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      dz_q        <= 1'b0;
      mul_cnt_q   <= '0;
      issued_q    <= 1'b0;
    end else if (flush) begin
      div_state_q <= DIV_IDLE;
      div_cnt_q   <= '0;
      mul_cnt_q   <= '0;
      issued_q    <= 1'b0;
    end else begin
      if (advance)                         issued_q <= 1'b0;
      else if (data_sram_en && !ms_allowin) issued_q <= 1'b1;

      if (capture && ds_is_mul)  mul_cnt_q <= MCW'(MUL_LAT - 1);
      else if (mul_cnt_q != '0)  mul_cnt_q <= mul_cnt_q - MCW'(1);

      if (capture && ds_is_div) begin
        div_state_q <= DIV_RUN;
        div_cnt_q   <= DCW'(XLEN);
        rem_q       <= '0;
        quo_q       <= ds_abs1;
        dvs_q       <= ds_abs2;
        q_neg_q     <= ds_a_neg ^ ds_b_neg;
        r_neg_q     <= ds_a_neg;
        dz_q        <= (ds_src2 == '0);
      end else begin
        case (div_state_q)
          DIV_RUN: begin
            if (dz_q) begin
              quo_q       <= DZ_QUO;
              rem_q       <= src1_q;
              div_state_q <= DIV_DONE;
            end else begin
              if (!rem_diff[XLEN]) begin
                rem_q <= rem_diff[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b1};
              end else begin
                rem_q <= rem_shift[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b0};
              end
              div_cnt_q <= div_cnt_q - DCW'(1);
              if (div_cnt_q == DCW'(1)) div_state_q <= DIV_DONE;
            end
          end
          DIV_DONE: if (advance) div_state_q <= DIV_IDLE;
          default: ;
        endcase
      end
    end
  end

  assign div_quo = dz_q ? quo_q : (q_neg_q ? -quo_q : quo_q);
  assign div_rem = dz_q ? rem_q : (r_neg_q ? -rem_q : rem_q);

  // Sign-extending to 2*XLEN makes the low 2*XLEN product bits exact for both signednesses.
  assign mul_sgn  = (op_q == OP_MULH);
  assign mul_a    = {{XLEN{mul_sgn & src1_q[XLEN-1]}}, src1_q};
  assign mul_b    = {{XLEN{mul_sgn & src2_q[XLEN-1]}}, src2_q};
  assign mul_prod = mul_a * mul_b;

  assign addr = src1_q + src2_q;
  assign lane = addr[AW-1:0];

  always_comb begin
    lane_be   = '1;
    lane_data = st_data_q;
    case (size_q)
      2'd0: begin
        lane_be   = NB'(1) << lane;
        lane_data = {NB{st_data_q[7:0]}};
      end
      2'd1: begin
        lane_be   = NB'(3) << lane;
        lane_data = {(XLEN/16){st_data_q[15:0]}};
      end
      2'd2: begin
        lane_be   = NB'(15) << lane;
        lane_data = {(XLEN/32){st_data_q[31:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    res = '0;
    case (op_q)
      OP_ADD:              res = src1_q + src2_q;
      OP_SUB:              res = src1_q - src2_q;
      OP_AND:              res = src1_q & src2_q;
      OP_OR:               res = src1_q | src2_q;
      OP_XOR:              res = src1_q ^ src2_q;
      OP_SLT:              res = {{(XLEN-1){1'b0}}, $signed(src1_q) < $signed(src2_q)};
      OP_SLTU:             res = {{(XLEN-1){1'b0}}, src1_q < src2_q};
      OP_MUL:              res = mul_prod[XLEN-1:0];
      OP_MULH, OP_MULHU:   res = mul_prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:     res = div_quo;
      OP_MOD, OP_MODU:     res = div_rem;
      OP_LOAD, OP_STORE:   res = addr;
      default:             res = '0;
    endcase
  end

  assign es_result       = es_valid_q ? res : '0;
  assign es_dest         = dest_q;
  assign es_gr_we        = es_valid_q && gr_we_q;
  assign es_pc           = pc_q;
  assign es_mem_size     = size_q;
  assign es_res_from_mem = es_valid_q && (op_q == OP_LOAD);
  // A load's data is not known here, so only the interlock dest is offered.
  assign es_fwd_valid    = es_valid_q && gr_we_q && es_ready_go && (op_q != OP_LOAD);
  assign es_fwd_dest     = dest_q;

  assign data_sram_en    = es_valid_q && is_mem && !issued_q && !flush;
  assign data_sram_wen   = (es_valid_q && (op_q == OP_STORE)) ? lane_be : '0;
  assign data_sram_addr  = addr;
  assign data_sram_wdata = lane_data;

endmodule
